// File: rtl/usb_gpx_pkg.sv
// Shared definitions for the GPX event controller.
//   - Register word addresses for the 4-register Avalon-MM slave.
//   - CTRL register bit positions.
//   - Glitch-filter state encoding.
package usb_gpx_pkg;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_CTRL   = 2'd1;
  localparam logic [1:0] ADDR_STATUS = 2'd2;
  localparam logic [1:0] ADDR_COUNT  = 2'd3;

  localparam int IRQ_EN   = 0;
  localparam int EDGE_SEL = 1;
  localparam int BOTH     = 2;
  localparam int FILT_LSB = 8;

  typedef enum logic [0:0] {
    STABLE  = 1'b0,
    QUALIFY = 1'b1
  } filt_state_e;

endpackage

// File: rtl/usb_gpx_filter.sv
// Synchronizer and programmable glitch filter for the raw GPX pin.
// Ports:
//   clk, reset  : system clock, synchronous active-high reset
//   in_port     : raw asynchronous pin
//   filt_len    : qualification length L (0 = pass-through after sync)
//   filt        : filtered level
//   rise, fall  : one-cycle pulses, asserted in the cycle filt shows its new level
module usb_gpx_filter
  import usb_gpx_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_W      = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_port,
  input  logic [FILT_W-1:0] filt_len,
  output logic              filt,
  output logic              rise,
  output logic              fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  filt_state_e            state_q, state_d;
  logic [FILT_W-1:0]      cnt_q, cnt_d;
  logic                   filt_q, filt_d;
  logic                   rise_q, fall_q;

  assign sync = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    filt_d  = filt_q;
    case (state_q)
      STABLE: begin
        if (sync != filt_q) begin
          if (filt_len == '0) begin
            filt_d = sync;
          end else begin
            // Counter holds the remaining QUALIFY cycles after this one, so
            // the commit lands L+1 cycles after sync changed.
            cnt_d   = filt_len - FILT_W'(1);
            state_d = QUALIFY;
          end
        end
      end
      QUALIFY: begin
        if (sync == filt_q) begin
          state_d = STABLE;
        end else if (cnt_q == '0) begin
          filt_d  = sync;
          state_d = STABLE;
        end else begin
          cnt_d = cnt_q - FILT_W'(1);
        end
      end
      default: state_d = STABLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q  <= '0;
      state_q <= STABLE;
      cnt_q   <= '0;
      filt_q  <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], in_port};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      filt_q  <= filt_d;
      rise_q  <= filt_d & ~filt_q;
      fall_q  <= ~filt_d & filt_q;
    end
  end

  assign filt = filt_q;
  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: rtl/usb_gpx_event_ctrl.sv
// GPX event controller: filtered pin level, edge capture into a sticky
// pending flag, saturating event counter and level IRQ behind a 4-word
// Avalon-MM slave.
// Ports:
//   clk, reset         : system clock, synchronous active-high reset
//   address, write,    : register access (word address, write strobe, data)
//   writedata
//   readdata           : registered read data, follows address every cycle
//   in_port            : raw asynchronous GPX pin
//   irq                : level interrupt (pending & irq_en), flop output
module usb_gpx_event_ctrl
  import usb_gpx_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_W      = 8,
  parameter int CNT_W       = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic        in_port,
  output logic        irq
);

  logic              irq_en_q, irq_en_d;
  logic              edge_sel_q, edge_sel_d;
  logic              both_q, both_d;
  logic [FILT_W-1:0] filt_len_q, filt_len_d;
  logic              pending_q, pending_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              irq_q, irq_d;
  logic [31:0]       readdata_q, readdata_d;
  logic              filt, rise, fall;
  logic              qual;
  logic              unused_wdata;

  assign unused_wdata = ^writedata;

  usb_gpx_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILT_W      (FILT_W)
  ) u_filter (
    .clk      (clk),
    .reset    (reset),
    .in_port  (in_port),
    .filt_len (filt_len_q),
    .filt     (filt),
    .rise     (rise),
    .fall     (fall)
  );

  assign qual = both_q ? (rise | fall) : (edge_sel_q ? fall : rise);

  always_comb begin
    irq_en_d   = irq_en_q;
    edge_sel_d = edge_sel_q;
    both_d     = both_q;
    filt_len_d = filt_len_q;
    pending_d  = pending_q;
    count_d    = count_q;

    if (write && address == ADDR_CTRL) begin
      irq_en_d   = writedata[IRQ_EN];
      edge_sel_d = writedata[EDGE_SEL];
      both_d     = writedata[BOTH];
      filt_len_d = writedata[FILT_LSB +: FILT_W];
    end
    if (write && address == ADDR_STATUS && writedata[0]) begin
      pending_d = 1'b0;
    end
    if (write && address == ADDR_COUNT) begin
      count_d = '0;
    end

    // Events are applied after the CPU clears so a coincident edge wins.
    if (qual) begin
      pending_d = 1'b1;
      if (count_d != {CNT_W{1'b1}}) begin
        count_d = count_d + CNT_W'(1);
      end
    end

    irq_d = pending_d & irq_en_d;

    // Read mux uses pre-write state.
    readdata_d = '0;
    case (address)
      ADDR_DATA:   readdata_d[0] = filt;
      ADDR_CTRL: begin
        readdata_d[IRQ_EN]              = irq_en_q;
        readdata_d[EDGE_SEL]            = edge_sel_q;
        readdata_d[BOTH]                = both_q;
        readdata_d[FILT_LSB +: FILT_W]  = filt_len_q;
      end
      ADDR_STATUS: readdata_d[0] = pending_q;
      ADDR_COUNT:  readdata_d[CNT_W-1:0] = count_q;
      default:     readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      irq_en_q   <= 1'b0;
      edge_sel_q <= 1'b0;
      both_q     <= 1'b0;
      filt_len_q <= '0;
      pending_q  <= 1'b0;
      count_q    <= '0;
      irq_q      <= 1'b0;
      readdata_q <= '0;
    end else begin
      irq_en_q   <= irq_en_d;
      edge_sel_q <= edge_sel_d;
      both_q     <= both_d;
      filt_len_q <= filt_len_d;
      pending_q  <= pending_d;
      count_q    <= count_d;
      irq_q      <= irq_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_usb_gpx_event_ctrl.sv
module tb_usb_gpx_event_ctrl;

  localparam logic [1:0] A_DATA   = 2'd0;
  localparam logic [1:0] A_CTRL   = 2'd1;
  localparam logic [1:0] A_STATUS = 2'd2;
  localparam logic [1:0] A_COUNT  = 2'd3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  address = 2'd0;
  logic        write = 1'b0;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        in_port = 1'b0;
  logic        irq;

  int n_cmp = 0;
  int n_mis = 0;
  logic [31:0] v;

  usb_gpx_event_ctrl #(
    .SYNC_STAGES (2),
    .FILT_W      (8),
    .CNT_W       (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .address   (address),
    .write     (write),
    .writedata (writedata),
    .readdata  (readdata),
    .in_port   (in_port),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // All tasks are entered and left at a negative clock edge.
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address   = a;
    writedata = d;
    write     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    write     = 1'b0;
    writedata = '0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    address = a;
    @(posedge clk);
    @(negedge clk);
    d = readdata;
  endtask

  initial begin
    // Reset with the pin already high.
    in_port = 1'b1;
    address = A_COUNT;
    idle(4);
    chk("rst_readdata", readdata, 32'h0);
    chk("rst_irq", {31'h0, irq}, 32'h0);
    reset = 1'b0;
    idle(4);
    rd(A_COUNT, v);  chk("post_rst_count", v, 32'd1);
    rd(A_STATUS, v); chk("post_rst_pending", v, 32'd1);
    rd(A_CTRL, v);   chk("post_rst_ctrl", v, 32'h0);

    // Falling edge is ignored in rising mode; then clear state.
    in_port = 1'b0;
    idle(6);
    wr(A_STATUS, 32'h1);
    wr(A_COUNT, 32'h0);
    rd(A_STATUS, v); chk("clr_pending", v, 32'd0);
    rd(A_COUNT, v);  chk("clr_count", v, 32'd0);

    // Glitch filter L=4, rising, irq_en.
    wr(A_CTRL, 32'h0000_0401);
    rd(A_CTRL, v);   chk("ctrl_rb", v, 32'h0000_0401);
    in_port = 1'b1;
    idle(3);
    in_port = 1'b0;
    idle(12);
    chk("glitch_irq", {31'h0, irq}, 32'h0);
    rd(A_COUNT, v);  chk("glitch_count", v, 32'd0);

    in_port = 1'b1;
    idle(7);
    chk("pulse_irq_early", {31'h0, irq}, 32'h0);
    idle(1);
    chk("pulse_irq_on_time", {31'h0, irq}, 32'h1);
    rd(A_DATA, v);   chk("pulse_data", v, 32'd1);
    idle(1);
    in_port = 1'b0;
    idle(12);
    rd(A_COUNT, v);  chk("pulse_count", v, 32'd1);
    rd(A_DATA, v);   chk("pulse_data_low", v, 32'd0);
    wr(A_STATUS, 32'h1);
    chk("w1c_irq", {31'h0, irq}, 32'h0);
    wr(A_COUNT, 32'h0);

    // Edge select: falling only, rise/fall/rise -> 1 event.
    wr(A_CTRL, 32'h2);
    in_port = 1'b1; idle(5);
    in_port = 1'b0; idle(5);
    in_port = 1'b1; idle(5);
    rd(A_COUNT, v);  chk("fall_only_count", v, 32'd1);
    wr(A_CTRL, 32'h0);
    in_port = 1'b0; idle(5);
    wr(A_COUNT, 32'h0);
    wr(A_CTRL, 32'h4);
    in_port = 1'b1; idle(5);
    in_port = 1'b0; idle(5);
    in_port = 1'b1; idle(5);
    rd(A_COUNT, v);  chk("both_count", v, 32'd3);

    // Collision: W1C in the cycle the qualified edge lands.
    wr(A_STATUS, 32'h1);
    rd(A_STATUS, v); chk("pre_coll_pending", v, 32'd0);
    in_port = 1'b0;
    idle(3);
    wr(A_STATUS, 32'h1);
    rd(A_STATUS, v); chk("coll_w1c_pending", v, 32'd1);
    rd(A_COUNT, v);  chk("coll_w1c_count", v, 32'd4);
    in_port = 1'b1;
    idle(3);
    wr(A_COUNT, 32'h0);
    rd(A_COUNT, v);  chk("coll_cnt_write", v, 32'd1);

    // Saturation with a 4-bit counter.
    for (int i = 0; i < 20; i++) begin
      in_port = ~in_port;
      idle(4);
    end
    rd(A_COUNT, v);  chk("sat_count", v, 32'd15);
    rd(A_STATUS, v); chk("sat_pending", v, 32'd1);
    wr(A_CTRL, 32'h5);
    chk("rw_same_cycle_old", readdata, 32'h4);
    chk("sat_irq_on", {31'h0, irq}, 32'h1);
    idle(1);
    chk("rw_new_value", readdata, 32'h5);
    wr(A_CTRL, 32'h4);
    chk("mask_irq_off", {31'h0, irq}, 32'h0);
    rd(A_STATUS, v); chk("mask_pending_kept", v, 32'd1);

    // Reset in the middle of an L=8 qualification.
    wr(A_CTRL, 32'h0);
    in_port = 1'b0;
    idle(5);
    wr(A_CTRL, 32'h0000_0800);
    wr(A_STATUS, 32'h1);
    wr(A_COUNT, 32'h0);
    in_port = 1'b1;
    idle(5);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    wr(A_CTRL, 32'h0000_0800);
    idle(4);
    in_port = 1'b0;
    idle(20);
    rd(A_STATUS, v); chk("midq_pending", v, 32'd0);
    rd(A_COUNT, v);  chk("midq_count", v, 32'd0);
    rd(A_DATA, v);   chk("midq_filt", v, 32'd0);
    chk("midq_irq", {31'h0, irq}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
